// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand, opcode, result and flag bundle for the alu
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output A, B, ALUControl,
    input  result, carry, overflow, zero
  );

  modport slave (
    input  A, B, ALUControl,
    output result, carry, overflow, zero
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - ADD/XOR/SUB/SLT alu with sticky overflow; ALU_OUTREG_EN registers the outputs
module alu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus,
  input  logic  sticky_clr,
  output logic  sticky_ovf
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;

  // One adder serves ADD, SUB and SLT; ALUControl[1] selects invert-and-increment.
  always_comb begin
    b_sel   = bus.ALUControl[1] ? ~bus.B : bus.B;
    sum     = {1'b0, bus.A} + {1'b0, b_sel} + {{WIDTH{1'b0}}, bus.ALUControl[1]};
    add_ovf = (bus.A[MSB] == b_sel[MSB]) && (sum[MSB] != bus.A[MSB]);
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (bus.ALUControl)
      2'b00, 2'b10: begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
        ovf_c   = add_ovf;
      end
      2'b01:   res_c = bus.A ^ bus.B;
      default: res_c = {{(WIDTH-1){1'b0}}, sum[MSB] ^ add_ovf};
    endcase
  end

`ifdef ALU_OUTREG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result   <= '0;
      bus.carry    <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
    end else begin
      bus.result   <= res_c;
      bus.carry    <= carry_c;
      bus.overflow <= ovf_c;
      bus.zero     <= ~|res_c;
    end
  end
`else
  always_comb begin
    bus.result   = res_c;
    bus.carry    = carry_c;
    bus.overflow = ovf_c;
    bus.zero     = ~|res_c;
  end
`endif

  // Clear outranks a simultaneous overflow so software can acknowledge reliably.
  always_ff @(posedge clk) begin
    if (reset)           sticky_ovf <= 1'b0;
    else if (sticky_clr) sticky_ovf <= 1'b0;
    else if (ovf_c)      sticky_ovf <= 1'b1;
  end
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed-vector self-checking bench for alu
module tb_alu;
  logic clk;
  logic reset;
  logic sticky_clr;
  logic sticky_ovf;
  int   n_checks;
  int   n_fail;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bus.A          = a;
    bus.B          = b;
    bus.ALUControl = op;
`ifdef ALU_OUTREG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] op, input logic [31:0] r,
                     input logic c, input logic o, input logic z);
    apply(a, b, op);
    check_eq({tag, ".result"},   bus.result,         r);
    check_eq({tag, ".carry"},    {31'd0, bus.carry},    {31'd0, c});
    check_eq({tag, ".overflow"}, {31'd0, bus.overflow}, {31'd0, o});
    check_eq({tag, ".zero"},     {31'd0, bus.zero},     {31'd0, z});
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    sticky_clr     = 1'b0;
    bus.A          = 32'h0;
    bus.B          = 32'h0;
    bus.ALUControl = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.sticky", {31'd0, sticky_ovf}, 32'd0);
`ifdef ALU_OUTREG_EN
    check_eq("reset.result", bus.result, 32'h0);
`endif
    reset = 1'b0;

    vec("add5_3",    32'h00000005, 32'h00000003, 2'b00, 32'h00000008, 1'b0, 1'b0, 1'b0);
    vec("xor_alt",   32'hAAAAAAAA, 32'h55555555, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    vec("xor_same",  32'h12345678, 32'h12345678, 2'b01, 32'h00000000, 1'b0, 1'b0, 1'b1);
    vec("sub10_5",   32'h0000000A, 32'h00000005, 2'b10, 32'h00000005, 1'b1, 1'b0, 1'b0);
    vec("sub5_10",   32'h00000005, 32'h0000000A, 2'b10, 32'hFFFFFFFB, 1'b0, 1'b0, 1'b0);
    vec("slt5_10",   32'h00000005, 32'h0000000A, 2'b11, 32'h00000001, 1'b0, 1'b0, 1'b0);
    vec("slt_min",   32'h80000000, 32'h00000001, 2'b11, 32'h00000001, 1'b0, 1'b0, 1'b0);
    vec("slt10_5",   32'h0000000A, 32'h00000005, 2'b11, 32'h00000000, 1'b0, 1'b0, 1'b1);
    vec("add_wrap",  32'hFFFFFFFF, 32'h00000001, 2'b00, 32'h00000000, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_eq("sticky.quiet", {31'd0, sticky_ovf}, 32'd0);

    @(posedge clk);
    #1;
    vec("add_ovf",   32'h7FFFFFFF, 32'h00000001, 2'b00, 32'h80000000, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_eq("sticky.set", {31'd0, sticky_ovf}, 32'd1);
    apply(32'h1, 32'h2, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    check_eq("sticky.hold", {31'd0, sticky_ovf}, 32'd1);

    vec("sub_ovf",   32'h80000000, 32'h00000001, 2'b10, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    check_eq("sticky.clr_wins", {31'd0, sticky_ovf}, 32'd0);
    sticky_clr     = 1'b0;
    bus.ALUControl = 2'b01;
    @(posedge clk);
    #1;
    check_eq("sticky.after_clr", {31'd0, sticky_ovf}, 32'd0);

    apply(32'h7FFFFFFF, 32'h00000001, 2'b00);
    @(posedge clk);
    #1;
    check_eq("sticky.reset_pre", {31'd0, sticky_ovf}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("sticky.reset", {31'd0, sticky_ovf}, 32'd0);
`ifdef ALU_OUTREG_EN
    check_eq("reset.out_result", bus.result, 32'h0);
    check_eq("reset.out_ovf", {31'd0, bus.overflow}, 32'd0);
`else
    check_eq("reset.comb_result", bus.result, 32'h80000000);
    check_eq("reset.comb_ovf", {31'd0, bus.overflow}, 32'd1);
`endif
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
32-bit integer ALU for the single-cycle/pipelined MIPS datapath, executing ADD, XOR, SUB and SLT selected by a 2-bit ALUControl.
- Primary result and flags (carry, overflow, zero) are combinational from A, B and ALUControl.
- A small clocked status block holds a sticky overflow flag for exception/debug logic.

Parameters:
WIDTH, 32, datapath width of A, B and result; all rules below scale with WIDTH.

Ports:
clk  input  1  system clock; all registers update on its rising edge.
reset  input  1  synchronous, active-high reset.
A  input  WIDTH  operand A (rs).
B  input  WIDTH  operand B (rt/immediate).
ALUControl  input  2  operation select: 00 ADD, 01 XOR, 10 SUB, 11 SLT.
sticky_clr  input  1  synchronous clear of sticky_ovf.
result  output  WIDTH  operation result.
carry  output  1  adder carry-out (ADD/SUB only).
overflow  output  1  signed two's-complement overflow (ADD/SUB only).
zero  output  1  high when result == 0.
sticky_ovf  output  1  registered: set when overflow was high on a rising edge, held until cleared.

Behaviour:
- Single shared adder: sum = A + (ALUControl[1] ? ~B : B) + ALUControl[1], computed WIDTH+1 bits wide; carry = bit WIDTH.
- ADD (00): result = A+B mod 2^WIDTH; carry = unsigned carry-out; overflow = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
- SUB (10): result = A-B mod 2^WIDTH; carry = carry-out of A+~B+1, so carry=1 means no borrow (A >= B unsigned); overflow = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
- XOR (01): result = A^B; carry = 0; overflow = 0.
- SLT (11): signed compare, result = {0..., lt}, where lt = diff[msb] XOR sub_overflow and diff = A-B; carry = 0; overflow = 0 (the internal subtraction overflow is not exported).
- zero = ~|result for every opcode, including XOR and SLT.
- result and all three flags are purely combinational: zero latency, no dependence on clk or reset, valid within the same cycle as input changes.
- sticky_ovf register, evaluated on each rising clk edge in this priority order:
  - reset=1 -> 0.
  - else sticky_clr=1 -> 0. Clear wins over a simultaneous overflow.
  - else overflow=1 -> 1.
  - else hold.
- Reset is synchronous and active-high. Asserting it mid-operation does not affect combinational outputs; only sticky_ovf is forced to 0 at the next edge.
- No X propagation from undefined opcodes: all four encodings are defined.

Optional Feature:
ALU_OUTREG_EN:
- Defined:
  - result, carry, overflow and zero are registered on rising clk, giving 1-cycle latency.
  - reset=1 drives all four to 0 on the next edge.
  - sticky_ovf samples the combinational (pre-register) overflow.
- Undefined: outputs are combinational as described above; sticky_ovf is the only state.

Test Plan:
- ADD A=00000005 B=00000003 op=00 -> result=00000008, carry=0, ovf=0, zero=0.
- XOR A=AAAAAAAA B=55555555 op=01 -> result=FFFFFFFF, carry=0, ovf=0, zero=0. Also A=B=12345678 -> result=0, zero=1.
- SUB A=0000000A B=00000005 op=10 -> result=00000005, carry=1, ovf=0. SUB A=00000005 B=0000000A -> result=FFFFFFFB, carry=0, ovf=0, zero=0.
- SLT:
  - A=00000005 B=0000000A op=11 -> result=00000001, zero=0.
  - A=80000000 B=00000001 -> result=00000001 (signed, despite sub overflow).
  - A=0000000A B=00000005 -> result=0, zero=1.
- Overflow:
  - ADD A=7FFFFFFF B=00000001 -> result=80000000, ovf=1, carry=0.
  - SUB A=80000000 B=00000001 -> result=7FFFFFFF, ovf=1, carry=1.
  - ADD FFFFFFFF+00000001 -> result=0, carry=1, ovf=0, zero=1.
- Sticky/reset:
  - Overflow held one edge -> sticky_ovf=1 next cycle and holds.
  - sticky_clr with overflow high -> sticky_ovf=0.
  - reset=1 -> sticky_ovf=0 at next edge; combinational result unaffected.
  - With ALU_OUTREG_EN: result appears one edge later; reset zeroes all outputs.
